// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;
  typedef enum logic [1:0] {IDLE, MEASURE, TIMEOUT} state_t;
  localparam int CNT_W_DEF  = 32;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/sig_sync_edge.sv
// Synchronizes the slow input, optionally glitch-filters it (PERIOD_METER_FILTER_EN),
// and produces registered level plus rise/fall pulses aligned to that level.
module sig_sync_edge
  import period_meter_pkg::*;
#(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_s,
  output logic rise,
  output logic fall
);
  logic [SYNC_DEPTH-1:0] sync;
  logic                  lvl;

  always_ff @(posedge clk) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_DEPTH-2:0], sig_in};
  end

`ifdef PERIOD_METER_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic [FW-1:0] stab;

  // Level flips only after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      lvl  <= 1'b0;
      stab <= '0;
    end else if (sync[SYNC_DEPTH-1] == lvl) begin
      stab <= '0;
    end else if (stab == FW'(FILTER_LEN - 1)) begin
      lvl  <= sync[SYNC_DEPTH-1];
      stab <= '0;
    end else begin
      stab <= stab + FW'(1);
    end
  end
`else
  assign lvl = sync[SYNC_DEPTH-1];
`endif

  // sig_s is the delayed level so it lines up with the rise/fall pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      sig_s <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      sig_s <= lvl;
      rise  <= lvl & ~sig_s;
      fall  <= ~lvl & sig_s;
    end
  end
endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow square wave in clk cycles.
// Optional glitch filter enabled by defining PERIOD_METER_FILTER_EN.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int               CNT_W      = CNT_W_DEF,
  parameter logic [CNT_W-1:0] MAX_COUNT  = '1,
  parameter int               FILTER_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_cycles,
  output logic [CNT_W-1:0] high_cycles,
  output logic             meas_valid,
  output logic             timeout,
  output logic             locked
);
  state_t           state;
  logic [CNT_W-1:0] cnt, hcnt;
  logic             sig_s, rise, fall;

  sig_sync_edge #(.FILTER_LEN(FILTER_LEN)) u_sync (
    .clk    (clk),
    .reset  (reset),
    .sig_in (sig_in),
    .sig_s  (sig_s),
    .rise   (rise),
    .fall   (fall)
  );

  assert property (@(posedge clk) disable iff (reset) !(rise && fall));

  // The rise cycle itself counts as the first cycle (and first high cycle) of a period.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      hcnt          <= '0;
      period_cycles <= '0;
      high_cycles   <= '0;
      meas_valid    <= 1'b0;
      timeout       <= 1'b0;
      locked        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= CNT_W'(1);
            hcnt  <= CNT_W'(1);
            state <= MEASURE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_cycles <= cnt;
            high_cycles   <= hcnt;
            meas_valid    <= 1'b1;
            locked        <= 1'b1;
            cnt           <= CNT_W'(1);
            hcnt          <= CNT_W'(1);
          end else if (cnt == MAX_COUNT) begin
            state   <= TIMEOUT;
            timeout <= 1'b1;
            locked  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (sig_s) hcnt <= hcnt + CNT_W'(1);
          end
        end
        TIMEOUT: begin
          if (rise) begin
            timeout <= 1'b0;
            cnt     <= CNT_W'(1);
            hcnt    <= CNT_W'(1);
            state   <= MEASURE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench: waveforms are built as sample arrays; expected outputs come
// from the rise times of the (optionally filtered) wave, not from the RTL structure.
module tb_period_meter;
  localparam int CW     = 32;
  localparam int MAXC   = 64;
  localparam int FL     = 4;
`ifdef PERIOD_METER_FILTER_EN
  localparam int FD     = FL;
`else
  localparam int FD     = 0;
`endif
  localparam int LAT    = 3;
  localparam int MAXLEN = 1024;
  localparam int VB     = 2*CW+2;
  localparam int TB     = 2*CW+1;
  localparam int LB     = 2*CW;
  localparam int MINH   = (FD > 1) ? FD : 1;
  localparam int DH     = (FD > 3) ? FD : 3;

  typedef logic [2*CW+2:0] obs_t;

  logic          clk = 1'b0;
  logic          reset, sig_in;
  logic [CW-1:0] period_cycles, high_cycles;
  logic          meas_valid, timeout, locked;

  bit   wave [MAXLEN];
  int   wlen;
  obs_t obs  [MAXLEN];
  obs_t expv [MAXLEN];
  int   checks = 0;
  int   errors = 0;

  period_meter #(.CNT_W(CW), .MAX_COUNT(CW'(MAXC)), .FILTER_LEN(FL)) dut (
    .clk           (clk),
    .reset         (reset),
    .sig_in        (sig_in),
    .period_cycles (period_cycles),
    .high_cycles   (high_cycles),
    .meas_valid    (meas_valid),
    .timeout       (timeout),
    .locked        (locked)
  );

  always #5 clk = ~clk;

  function automatic void clear_wave();
    wlen = 0;
  endfunction

  function automatic void add(input bit v, input int n);
    for (int i = 0; i < n; i++)
      if (wlen < MAXLEN) begin
        wave[wlen] = v;
        wlen++;
      end
  endfunction

  // Reference: filtered level -> rise list -> measurement/timeout/recovery events.
  function automatic void build_expect();
    bit fw [MAXLEN];
    int ev [MAXLEN];
    int ep [MAXLEN];
    int eh [MAXLEN];
    int rises[$];
    bit prev, same, v0, vl, to, lk;
    int p, h, t, g;
    prev = 1'b0;
    for (int i = 0; i < MAXLEN; i++) begin
      ev[i] = 0; ep[i] = 0; eh[i] = 0;
    end
    for (int i = 0; i < wlen; i++) begin
      if (FD == 0) fw[i] = wave[i];
      else begin
        same = 1'b1;
        v0   = (i - FD >= 0) ? wave[i-FD] : 1'b0;
        for (int k = i - FD + 1; k < i; k++)
          if (((k >= 0) ? wave[k] : 1'b0) != v0) same = 1'b0;
        fw[i] = same ? v0 : ((i > 0) ? fw[i-1] : 1'b0);
      end
      if (fw[i] && !prev) rises.push_back(i);
      prev = fw[i];
    end
    for (int k = 1; k < rises.size(); k++) begin
      g = rises[k] - rises[k-1];
      if (g <= MAXC) begin
        t = rises[k] + LAT;
        if (t < wlen) begin
          ev[t] = 1; ep[t] = g; eh[t] = 0;
          for (int i = rises[k-1]; i < rises[k]; i++) eh[t] += int'(fw[i]);
        end
      end else begin
        t = rises[k-1] + MAXC + LAT;
        if (t < wlen) ev[t] = 2;
        t = rises[k] + LAT;
        if (t < wlen) ev[t] = 3;
      end
    end
    if (rises.size() > 0) begin
      t = rises[rises.size()-1] + MAXC + LAT;
      if (t < wlen) ev[t] = 2;
    end
    vl = 0; to = 0; lk = 0; p = 0; h = 0;
    for (int j = 0; j < wlen; j++) begin
      vl = 0;
      case (ev[j])
        1: begin vl = 1; p = ep[j]; h = eh[j]; lk = 1; end
        2: begin to = 1; lk = 0; end
        3: to = 0;
        default: ;
      endcase
      expv[j] = {vl, to, lk, CW'(p), CW'(h)};
    end
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    sig_in = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic run_wave();
    for (int j = 0; j < wlen; j++) begin
      sig_in = wave[j];
      @(negedge clk);
      obs[j] = {meas_valid, timeout, locked, period_cycles, high_cycles};
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({meas_valid, timeout, locked, period_cycles, high_cycles} !== '0) begin
      errors++;
      $display("FAIL reset_state got=%h exp=0", {meas_valid, timeout, locked, period_cycles, high_cycles});
    end
    clear_wave(); add(0, 100); build_expect(); run_wave();
    for (int j = 0; j < wlen; j++) begin
      checks++;
      if (obs[j] !== '0) begin
        errors++;
        $display("FAIL idle cyc=%0d got=%h exp=0", j, obs[j]);
      end
    end
  endtask

  task automatic test_square();
    int n = 0;
    do_reset();
    clear_wave();
    for (int k = 0; k < 4; k++) begin add(1, 5); add(0, 5); end
    build_expect(); run_wave();
    for (int j = 0; j < wlen; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL square cyc=%0d got=%h exp=%h", j, obs[j], expv[j]);
      end
      if (obs[j][VB]) n++;
    end
    checks++;
    if (n != 3 || obs[wlen-1][2*CW-1:CW] !== CW'(10) || obs[wlen-1][CW-1:0] !== CW'(5) || !obs[wlen-1][LB]) begin
      errors++;
      $display("FAIL square_summary got pulses=%0d p=%0d h=%0d lk=%b exp pulses=3 p=10 h=5 lk=1",
               n, obs[wlen-1][2*CW-1:CW], obs[wlen-1][CW-1:0], obs[wlen-1][LB]);
    end
  endtask

  task automatic test_duty();
    do_reset();
    clear_wave();
    for (int k = 0; k < 4; k++) begin add(1, DH); add(0, 12 - DH); end
    build_expect(); run_wave();
    for (int j = 0; j < wlen; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL duty cyc=%0d got=%h exp=%h", j, obs[j], expv[j]);
      end
    end
    checks++;
    if (!obs[15+FD][VB] || obs[15+FD][2*CW-1:CW] !== CW'(12) || obs[15+FD][CW-1:0] !== CW'(DH)) begin
      errors++;
      $display("FAIL duty_first got=%h exp p=12 h=%0d valid", obs[15+FD], DH);
    end
  endtask

  task automatic test_stall();
    int n = 0;
    do_reset();
    clear_wave();
    add(1, 5); add(0, 5); add(1, 5); add(0, 105);
    for (int k = 0; k < 3; k++) begin add(1, 5); add(0, 5); end
    build_expect(); run_wave();
    for (int j = 0; j < wlen; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL stall cyc=%0d got=%h exp=%h", j, obs[j], expv[j]);
      end
      if (j > 77 + FD && j < 133 + FD && obs[j][VB]) n++;
    end
    checks++;
    if (obs[76+FD][TB] || !obs[77+FD][TB] || obs[77+FD][LB] || obs[77+FD][2*CW-1:CW] !== CW'(10)) begin
      errors++;
      $display("FAIL stall_timeout got@76=%h got@77=%h exp timeout rising at 77, locked 0, p=10",
               obs[76+FD], obs[77+FD]);
    end
    checks++;
    if (obs[123+FD][TB] || n != 0 || !obs[133+FD][VB] || obs[133+FD][2*CW-1:CW] !== CW'(10)) begin
      errors++;
      $display("FAIL stall_recover got@123=%h early_pulses=%0d got@133=%h exp timeout 0, no early pulse, p=10",
               obs[123+FD], n, obs[133+FD]);
    end
  endtask

  task automatic test_const_high();
    do_reset();
    clear_wave(); add(1, 100);
    build_expect(); run_wave();
    for (int j = 0; j < wlen; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL const_high cyc=%0d got=%h exp=%h", j, obs[j], expv[j]);
      end
    end
    checks++;
    if (!obs[wlen-1][TB]) begin
      errors++;
      $display("FAIL const_high_timeout got=%b exp=1", obs[wlen-1][TB]);
    end
  endtask

  task automatic test_boundary();
    do_reset();
    clear_wave();
    add(1, 5); add(0, 5);
    add(1, 5); add(0, 59);
    add(1, 5); add(0, 60);
    add(1, 5); add(0, 5); add(1, 5); add(0, 5); add(1, 5); add(0, 5);
    build_expect(); run_wave();
    for (int j = 0; j < wlen; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL boundary cyc=%0d got=%h exp=%h", j, obs[j], expv[j]);
      end
    end
    checks++;
    if (!obs[77+FD][VB] || obs[77+FD][TB] || obs[77+FD][2*CW-1:CW] !== CW'(MAXC) || !obs[141+FD][TB]) begin
      errors++;
      $display("FAIL boundary_max got@77=%h got@141=%h exp p=%0d valid no timeout, then timeout",
               obs[77+FD], obs[141+FD], MAXC);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    do_reset();
    clear_wave();
    for (int k = 0; k < 3; k++) begin add(1, 5); add(0, 5); end
    add(1, 4);
    build_expect(); run_wave();
    for (int j = 0; j < wlen; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL mid_pre cyc=%0d got=%h exp=%h", j, obs[j], expv[j]);
      end
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({meas_valid, timeout, locked, period_cycles, high_cycles} !== '0) begin
      errors++;
      $display("FAIL mid_reset got=%h exp=0", {meas_valid, timeout, locked, period_cycles, high_cycles});
    end
    reset = 1'b0;
    clear_wave();
    for (int k = 0; k < 2; k++) begin add(1, 5); add(0, 5); end
    build_expect(); run_wave();
    for (int j = 0; j < wlen; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL mid_post cyc=%0d got=%h exp=%h", j, obs[j], expv[j]);
      end
      if (obs[j][VB]) n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL mid_post_count got=%0d exp=1", n);
    end
  endtask

  task automatic test_random();
    int hi, lo;
    for (int it = 0; it < 4; it++) begin
      do_reset();
      clear_wave();
      while (wlen < 300) begin
        hi = $urandom_range(12, MINH);
        lo = ($urandom_range(9, 0) == 0) ? $urandom_range(80, 55) : $urandom_range(12, MINH);
        add(1, hi); add(0, lo);
      end
      build_expect(); run_wave();
      for (int j = 0; j < wlen; j++) begin
        checks++;
        if (obs[j] !== expv[j]) begin
          errors++;
          $display("FAIL random it=%0d cyc=%0d got=%h exp=%h", it, j, obs[j], expv[j]);
        end
        if (j > 0) begin
          checks++;
          if (obs[j][VB] && obs[j-1][VB]) begin
            errors++;
            $display("FAIL random_b2b it=%0d cyc=%0d got two valid cycles exp at most one", it, j);
          end
        end
      end
    end
  endtask

`ifdef PERIOD_METER_FILTER_EN
  task automatic test_filter();
    int n = 0;
    int first = -1;
    do_reset();
    clear_wave();
    add(1, 6); add(0, 8); add(1, 2); add(0, 10);
    add(1, 6); add(0, 20); add(1, 4); add(0, 6); add(1, 6); add(0, 6);
    build_expect(); run_wave();
    for (int j = 0; j < wlen; j++) begin
      checks++;
      if (obs[j] !== expv[j]) begin
        errors++;
        $display("FAIL filter cyc=%0d got=%h exp=%h", j, obs[j], expv[j]);
      end
      if (obs[j][VB]) begin
        n++;
        if (first < 0) first = int'(obs[j][2*CW-1:CW]);
      end
    end
    checks++;
    if (n != 3 || first != 26) begin
      errors++;
      $display("FAIL filter_glitch got pulses=%0d first_p=%0d exp pulses=3 first_p=26", n, first);
    end
  endtask
`endif

  initial begin
    reset  = 1'b1;
    sig_in = 1'b0;
    test_reset();
    test_square();
    test_duty();
    test_stall();
    test_const_high();
    test_boundary();
    test_mid_reset();
    test_random();
`ifdef PERIOD_METER_FILTER_EN
    test_filter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
